approx_dot_accumulator: RTL

APPROX_DOT_ACCUMULATOR -- requirements
Module: approx_dot_accumulator

---
 rtl/approx_dot_accumulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/approx_dot_accumulator.sv
// ---------------------------------------------------------------------------
// approx_dot_accumulator
//
// Accumulates a stream of unsigned 16-bit products, typically from an 8x8
// approximate multiplier, into a saturating dot-product sum. It emits one
// result per vector. A vector ends on in_last, or it is force-closed after
// MAX_LEN beats.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   clr       : synchronous soft clear; has priority over every other event
//   in_valid  : product beat valid
//   in_ready  : block accepts a beat (high only in ACCUM)
//   in_prod   : unsigned 16-bit product
//   in_last   : beat is the final element of the vector
//   out_valid : result valid
//   out_ready : downstream accepts the result
//   out_sum   : saturated dot-product sum
//   out_count : number of beats folded into the result
//   out_ovf   : sum saturated at 2^ACC_W-1
//   out_trunc : vector was force-closed at MAX_LEN
// ---------------------------------------------------------------------------
module approx_dot_accumulator #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             trunc;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             hit_max;
  logic             closing;
  logic             trunc_next;
  logic             accept;

  // in_ready is decoded from the registered state only. This keeps the
  // input handshake free of combinational paths from in_valid or out_ready.
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;

  always_comb begin
    sum_wide   = {1'b0, acc} + {{(ACC_W-15){1'b0}}, in_prod};
    // Overflow is sticky. After a saturation, the accumulator is pinned at
    // all-ones for the rest of the vector.
    ovf_next   = ovf | sum_wide[ACC_W];
    acc_next   = ovf_next ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    cnt_next   = cnt + CNT_W'(1);
    hit_max    = (cnt_next == CNT_W'(MAX_LEN));
    closing    = in_last | hit_max;
    trunc_next = trunc | (hit_max & ~in_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      trunc     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else if (clr) begin
      // Drop the partial vector and any pending result. A beat offered in
      // the same cycle is discarded.
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      trunc     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            trunc <= trunc_next;
            if (closing) begin
              out_sum   <= acc_next;
              out_count <= cnt_next;
              out_ovf   <= ovf_next;
              out_trunc <= trunc_next;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          // The result stays frozen until it is taken. The next beat can
          // then be accepted one cycle later.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            trunc     <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
